// File: rtl/ask2_tx_frame_ctrl.sv
// Frame sequencer for the 2ASK transmit path: gates the carrier per bit (on-off keying),
// framing each burst as filter clear + preamble + MSB-first bytes + carrier-off flush.
module ask2_tx_frame_ctrl #(
    parameter int unsigned SPB       = 50,
    parameter int unsigned PRE_BITS  = 8,
    parameter logic [15:0] PRE_PAT   = 16'hAAAA,
    parameter int unsigned FLUSH_CYC = 32
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       carrier_en,
    output logic       bit_out,
    output logic       sym_start,
    output logic       filter_clr,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BIT_MAX = (PRE_BITS > 8) ? PRE_BITS : 8;
    localparam int unsigned SW      = $clog2(SPB);
    localparam int unsigned BW      = $clog2(BIT_MAX);
    localparam int unsigned FW      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [SW-1:0] SMP_LAST   = SW'(SPB - 1);
    localparam logic [BW-1:0] PRE_LAST   = (PRE_BITS > 0) ? BW'(PRE_BITS - 1) : '0;
    localparam logic [BW-1:0] DATA_LAST  = BW'(7);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_PRE,
        S_DATA,
        S_FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] smp_q, smp_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [FW-1:0] flush_q, flush_d;
    logic [7:0]    shreg_q, shreg_d;

    logic tx_ready_q, tx_ready_d;
    logic carrier_en_q, carrier_en_d;
    logic sym_start_q, sym_start_d;
    logic filter_clr_q, filter_clr_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    logic xfer;
    assign xfer = tx_valid & tx_ready_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            smp_q        <= '0;
            bit_q        <= '0;
            flush_q      <= '0;
            shreg_q      <= '0;
            tx_ready_q   <= 1'b0;
            carrier_en_q <= 1'b0;
            sym_start_q  <= 1'b0;
            filter_clr_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_q        <= smp_d;
            bit_q        <= bit_d;
            flush_q      <= flush_d;
            shreg_q      <= shreg_d;
            tx_ready_q   <= tx_ready_d;
            carrier_en_q <= carrier_en_d;
            sym_start_q  <= sym_start_d;
            filter_clr_q <= filter_clr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        bit_d   = bit_q;
        flush_d = flush_q;
        shreg_d = shreg_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    state_d = S_CLR;
                    shreg_d = tx_data;
                end
            end
            S_CLR: begin
                smp_d = '0;
                if (PRE_BITS > 0) begin
                    state_d = S_PRE;
                    bit_d   = PRE_LAST;
                end else begin
                    state_d = S_DATA;
                    bit_d   = DATA_LAST;
                end
            end
            S_PRE: begin
                if (smp_q == SMP_LAST) begin
                    smp_d = '0;
                    if (bit_q == '0) begin
                        state_d = S_DATA;
                        bit_d   = DATA_LAST;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end else begin
                    smp_d = smp_q + 1'b1;
                end
            end
            S_DATA: begin
                if (smp_q == SMP_LAST) begin
                    smp_d = '0;
                    if (bit_q == '0) begin
                        // A byte accepted on the last clock of bit 0 chains with no gap.
                        if (xfer) begin
                            shreg_d = tx_data;
                            bit_d   = DATA_LAST;
                        end else begin
                            state_d = S_FLUSH;
                            flush_d = '0;
                        end
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end else begin
                    smp_d = smp_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output leaves a flop.
    always_comb begin
        carrier_en_d = 1'b0;
        if (state_d == S_PRE) begin
            carrier_en_d = PRE_PAT[bit_d];
        end else if (state_d == S_DATA) begin
            carrier_en_d = shreg_d[7];
        end
        sym_start_d  = ((state_d == S_PRE) || (state_d == S_DATA)) && (smp_d == '0);
        tx_ready_d   = (state_d == S_IDLE) ||
                       ((state_d == S_DATA) && (bit_d == '0) && (smp_d == SMP_LAST));
        filter_clr_d = (state_d == S_CLR);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_FLUSH) && (flush_d == FLUSH_LAST);
    end

    assign tx_ready   = tx_ready_q;
    assign carrier_en = carrier_en_q;
    assign bit_out    = carrier_en_q;
    assign sym_start  = sym_start_q;
    assign filter_clr = filter_clr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
